// File: rtl/vpu_cmd_unit_if.sv
// CPU<->VPU command bus: command operands in, results and status out,
// plus the draw req/ack pair towards the rasterizer.
// Ports: master = CPU/rasterizer side, slave = vpu_cmd_unit.
interface vpu_cmd_unit_if #(
  parameter int OBJ_W  = 5,
  parameter int DATA_W = 16
);
  // command side
  logic              start_VPU;
  logic [3:0]        op_VPU;
  logic [3:0]        code_VPU;
  logic [OBJ_W-1:0]  obj_num_VPU;
  logic [1:0]        obj_type_VPU;
  logic [2:0]        obj_color_VPU;
  logic              fill_VPU;
  logic [DATA_W-1:0] V0_VPU, V1_VPU, V2_VPU, V3_VPU;
  logic [DATA_W-1:0] V4_VPU, V5_VPU, V6_VPU, V7_VPU;
  logic [DATA_W-1:0] RO_VPU;

  // result side
  logic              VPU_rdy;
  logic              VPU_data_we;
  logic [DATA_W-1:0] VPU_V0, VPU_V1, VPU_V2, VPU_V3;
  logic [DATA_W-1:0] VPU_V4, VPU_V5, VPU_V6, VPU_V7;
  logic [DATA_W-1:0] VPU_RO;
  logic              err;

  // rasterizer side
  logic              draw_req;
  logic              draw_ack;
  logic [OBJ_W-1:0]  draw_obj;
  logic [1:0]        draw_type;
  logic [2:0]        draw_color;
  logic              draw_fill;

  modport master (
    output start_VPU, op_VPU, code_VPU, obj_num_VPU, obj_type_VPU,
           obj_color_VPU, fill_VPU, V0_VPU, V1_VPU, V2_VPU, V3_VPU,
           V4_VPU, V5_VPU, V6_VPU, V7_VPU, RO_VPU, draw_ack,
    input  VPU_rdy, VPU_data_we, VPU_V0, VPU_V1, VPU_V2, VPU_V3,
           VPU_V4, VPU_V5, VPU_V6, VPU_V7, VPU_RO, err,
           draw_req, draw_obj, draw_type, draw_color, draw_fill
  );

  modport slave (
    input  start_VPU, op_VPU, code_VPU, obj_num_VPU, obj_type_VPU,
           obj_color_VPU, fill_VPU, V0_VPU, V1_VPU, V2_VPU, V3_VPU,
           V4_VPU, V5_VPU, V6_VPU, V7_VPU, RO_VPU, draw_ack,
    output VPU_rdy, VPU_data_we, VPU_V0, VPU_V1, VPU_V2, VPU_V3,
           VPU_V4, VPU_V5, VPU_V6, VPU_V7, VPU_RO, err,
           draw_req, draw_obj, draw_type, draw_color, draw_fill
  );
endinterface

// File: rtl/vpu_cmd_unit.sv
// VPU command endpoint: per-object vertex RAM with LOAD / READ / XFORM / DRAW.
// Ports: clk, rst (async, active-high), bus (vpu_cmd_unit_if.slave).
// Latency from accept: LOAD 10, READ 11, XFORM 17 cycles; DRAW waits for ack.
module vpu_cmd_unit #(
  parameter int NUM_OBJ = 32,
  parameter int DATA_W  = 16
) (
  input  logic           clk,
  input  logic           rst,
  vpu_cmd_unit_if.slave  bus
);

  localparam int OBJ_W = $clog2(NUM_OBJ);
  localparam int AW    = OBJ_W + 4;

  localparam logic [3:0] OP_NOP   = 4'd0;
  localparam logic [3:0] OP_LOAD  = 4'd1;
  localparam logic [3:0] OP_READ  = 4'd2;
  localparam logic [3:0] OP_XFORM = 4'd3;
  localparam logic [3:0] OP_DRAW  = 4'd4;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_RD, S_RD_LAST, S_XF_RD, S_XF_WR, S_RET, S_DRAW
  } state_t;

  state_t state, state_nxt;
  logic [3:0] k, k_nxt;
  logic       reject;
  logic       accept;
  logic       rdy;

  // latched command
  logic [OBJ_W-1:0]  cmd_obj;
  logic              cmd_sub;
  logic [1:0]        cmd_type;
  logic [2:0]        cmd_color;
  logic              cmd_fill;
  logic [DATA_W-1:0] cmd_v [0:7];
  logic [DATA_W-1:0] cmd_ro;

  // per-slot attributes
  logic [NUM_OBJ-1:0] valid;
  logic [1:0]         obj_type  [0:NUM_OBJ-1];
  logic [2:0]         obj_color [0:NUM_OBJ-1];
  logic               obj_fill  [0:NUM_OBJ-1];

  // object RAM, address {obj, word}
  logic [DATA_W-1:0] mem [0:NUM_OBJ*16-1];
  logic [AW-1:0]     ram_addr;
  logic              ram_we;
  logic [DATA_W-1:0] ram_wd;
  logic [DATA_W-1:0] ram_q;
  logic [DATA_W-1:0] xf_val;

  // staging collects words as they arrive; out_v is what the CPU sees and
  // only changes on the edge that enters RET, so results stay stable
  // between strobes.
  logic [DATA_W-1:0] stg     [0:8];
  logic [DATA_W-1:0] stg_nxt [0:8];
  logic [DATA_W-1:0] out_v   [0:8];
  logic              commit;
  logic              err_q;

  // only bit 0 of the modifier has a meaning
  logic unused_code;
  assign unused_code = ^bus.code_VPU[3:1];

  // RET doubles as an idle state so a new command can follow the strobe
  assign rdy    = (state == S_IDLE) || (state == S_RET);
  assign accept = rdy && bus.start_VPU;

  // ---------------- next-state logic ----------------
  always_comb begin
    state_nxt = state;
    k_nxt     = k;
    reject    = 1'b0;
    case (state)
      S_IDLE, S_RET: begin
        state_nxt = S_IDLE;
        k_nxt     = 4'd0;
        if (bus.start_VPU) begin
          case (bus.op_VPU)
            OP_NOP:   state_nxt = S_IDLE;
            OP_LOAD:  state_nxt = S_LOAD;
            OP_READ:  if (valid[bus.obj_num_VPU]) state_nxt = S_RD;    else reject = 1'b1;
            OP_XFORM: if (valid[bus.obj_num_VPU]) state_nxt = S_XF_RD; else reject = 1'b1;
            OP_DRAW:  if (valid[bus.obj_num_VPU]) state_nxt = S_DRAW;  else reject = 1'b1;
            default:  reject = 1'b1;
          endcase
        end
      end
      S_LOAD: begin
        if (k == 4'd8) begin
          state_nxt = S_IDLE;
          k_nxt     = 4'd0;
        end else begin
          k_nxt = k + 4'd1;
        end
      end
      S_RD: begin
        if (k == 4'd8) state_nxt = S_RD_LAST;
        else           k_nxt     = k + 4'd1;
      end
      S_RD_LAST: state_nxt = S_RET;
      S_XF_RD:   state_nxt = S_XF_WR;
      S_XF_WR: begin
        if (k == 4'd7) state_nxt = S_RET;
        else begin
          state_nxt = S_XF_RD;
          k_nxt     = k + 4'd1;
        end
      end
      S_DRAW: if (bus.draw_ack) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // ---------------- RAM port control ----------------
  assign xf_val = cmd_sub ? (ram_q - cmd_ro) : (ram_q + cmd_ro);

  always_comb begin
    ram_addr = {cmd_obj, k};
    ram_we   = (state == S_LOAD) || (state == S_XF_WR);
    ram_wd   = xf_val;
    if (state == S_LOAD) ram_wd = (k == 4'd8) ? cmd_ro : cmd_v[k[2:0]];
  end

  // no reset on storage: contents are meaningless until the valid bit is set
  always_ff @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wd;
    ram_q <= mem[ram_addr];
  end

  // ---------------- staging ----------------
  always_comb begin
    for (int i = 0; i < 9; i++) stg_nxt[i] = stg[i];
    // read data lags the address by one cycle, hence word k-1
    if (state == S_RD && k != 4'd0) stg_nxt[k - 4'd1] = ram_q;
    if (state == S_RD_LAST)         stg_nxt[8]        = ram_q;
    if (state == S_XF_WR) begin
      stg_nxt[k] = xf_val;
      stg_nxt[8] = cmd_ro;
    end
  end

  assign commit = (state == S_RD_LAST) || (state == S_XF_WR && k == 4'd7);

  // ---------------- state registers ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      k         <= 4'd0;
      err_q     <= 1'b0;
      valid     <= '0;
      cmd_obj   <= '0;
      cmd_sub   <= 1'b0;
      cmd_type  <= '0;
      cmd_color <= '0;
      cmd_fill  <= 1'b0;
      cmd_ro    <= '0;
      for (int i = 0; i < 8; i++) cmd_v[i] <= '0;
      for (int i = 0; i < 9; i++) begin
        stg[i]   <= '0;
        out_v[i] <= '0;
      end
      for (int i = 0; i < NUM_OBJ; i++) begin
        obj_type[i]  <= '0;
        obj_color[i] <= '0;
        obj_fill[i]  <= 1'b0;
      end
    end else begin
      state <= state_nxt;
      k     <= k_nxt;
      err_q <= reject;
      for (int i = 0; i < 9; i++) stg[i] <= stg_nxt[i];
      if (commit) begin
        for (int i = 0; i < 9; i++) out_v[i] <= stg_nxt[i];
      end
      if (accept) begin
        cmd_obj   <= bus.obj_num_VPU;
        cmd_sub   <= bus.code_VPU[0];
        cmd_type  <= bus.obj_type_VPU;
        cmd_color <= bus.obj_color_VPU;
        cmd_fill  <= bus.fill_VPU;
        cmd_ro    <= bus.RO_VPU;
        cmd_v[0]  <= bus.V0_VPU;
        cmd_v[1]  <= bus.V1_VPU;
        cmd_v[2]  <= bus.V2_VPU;
        cmd_v[3]  <= bus.V3_VPU;
        cmd_v[4]  <= bus.V4_VPU;
        cmd_v[5]  <= bus.V5_VPU;
        cmd_v[6]  <= bus.V6_VPU;
        cmd_v[7]  <= bus.V7_VPU;
      end
      // slot becomes visible only once every word has landed
      if (state == S_LOAD && k == 4'd8) begin
        valid[cmd_obj]     <= 1'b1;
        obj_type[cmd_obj]  <= cmd_type;
        obj_color[cmd_obj] <= cmd_color;
        obj_fill[cmd_obj]  <= cmd_fill;
      end
    end
  end

  // ---------------- outputs ----------------
  assign bus.VPU_rdy     = rdy;
  assign bus.VPU_data_we = (state == S_RET);
  assign bus.err         = err_q;
  assign bus.VPU_V0      = out_v[0];
  assign bus.VPU_V1      = out_v[1];
  assign bus.VPU_V2      = out_v[2];
  assign bus.VPU_V3      = out_v[3];
  assign bus.VPU_V4      = out_v[4];
  assign bus.VPU_V5      = out_v[5];
  assign bus.VPU_V6      = out_v[6];
  assign bus.VPU_V7      = out_v[7];
  assign bus.VPU_RO      = out_v[8];

  assign bus.draw_req   = (state == S_DRAW);
  assign bus.draw_obj   = (state == S_DRAW) ? cmd_obj            : '0;
  assign bus.draw_type  = (state == S_DRAW) ? obj_type[cmd_obj]  : '0;
  assign bus.draw_color = (state == S_DRAW) ? obj_color[cmd_obj] : '0;
  assign bus.draw_fill  = (state == S_DRAW) ? obj_fill[cmd_obj]  : 1'b0;

endmodule

// File: tb/tb_vpu_cmd_unit.sv
module tb_vpu_cmd_unit;

  typedef logic [8:0][15:0] resp_t;   // [0..7] = V0..V7, [8] = RO

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  vpu_cmd_unit_if bus ();
  vpu_cmd_unit #(.NUM_OBJ(32), .DATA_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  resp_t sb_q[$];
  logic [15:0] mdl     [32][9];
  logic        mdl_vld [32];

  logic [7:0][15:0] vtx;
  logic [1:0] a_type;
  logic [2:0] a_color;
  logic       a_fill;

  task automatic check_int(input string tag, input int obs, input int exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_resp(input string tag, input resp_t obs, input resp_t exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic resp_t observed();
    resp_t r;
    r[0] = bus.VPU_V0; r[1] = bus.VPU_V1; r[2] = bus.VPU_V2; r[3] = bus.VPU_V3;
    r[4] = bus.VPU_V4; r[5] = bus.VPU_V5; r[6] = bus.VPU_V6; r[7] = bus.VPU_V7;
    r[8] = bus.VPU_RO;
    return r;
  endfunction

  task automatic set_v(input logic [7:0][15:0] v);
    bus.V0_VPU = v[0]; bus.V1_VPU = v[1]; bus.V2_VPU = v[2]; bus.V3_VPU = v[3];
    bus.V4_VPU = v[4]; bus.V5_VPU = v[5]; bus.V6_VPU = v[6]; bus.V7_VPU = v[7];
  endtask

  // Called one step after a rising edge; that edge+1 accepts the command.
  // Returns one step into cycle 1. Updates the reference model and pushes
  // the expected result for READ/XFORM on a loaded slot.
  task automatic send(input logic [3:0] op, input logic [3:0] code,
                      input logic [4:0] obj, input logic [15:0] ro);
    resp_t e;
    bus.op_VPU = op; bus.code_VPU = code; bus.obj_num_VPU = obj;
    bus.obj_type_VPU = a_type; bus.obj_color_VPU = a_color; bus.fill_VPU = a_fill;
    set_v(vtx); bus.RO_VPU = ro;
    bus.start_VPU = 1'b1;
    @(posedge clk); #1;
    bus.start_VPU = 1'b0;
    // operands are don't-care after acceptance
    set_v({8{16'hDEAD}}); bus.RO_VPU = 16'hBEEF; bus.op_VPU = 4'd0; bus.obj_num_VPU = 5'd0;
    if (op == 4'd1) begin
      for (int i = 0; i < 8; i++) mdl[obj][i] = vtx[i];
      mdl[obj][8]  = ro;
      mdl_vld[obj] = 1'b1;
    end else if (op == 4'd2 && mdl_vld[obj]) begin
      for (int i = 0; i < 9; i++) e[i] = mdl[obj][i];
      sb_q.push_back(e);
    end else if (op == 4'd3 && mdl_vld[obj]) begin
      for (int i = 0; i < 8; i++) begin
        mdl[obj][i] = code[0] ? (mdl[obj][i] - ro) : (mdl[obj][i] + ro);
        e[i] = mdl[obj][i];
      end
      e[8] = ro;
      sb_q.push_back(e);
    end
  endtask

  // Watches cycles 1.. until VPU_rdy returns; checks strobe data against the
  // scoreboard, the rdy/strobe cycles and that the strobe lasts one cycle.
  // pulse_cyc > 0 raises a stray start_VPU during that busy cycle.
  task automatic wait_done(input string tag, input int exp_rdy, input int exp_strobe,
                           input int pulse_cyc);
    int first_rdy = 0;
    int strobe_at = 0;
    int err_seen  = 0;
    for (int n = 1; n <= 40 && first_rdy == 0; n++) begin
      if (n == pulse_cyc) begin
        bus.op_VPU = 4'd2; bus.obj_num_VPU = 5'd3; bus.start_VPU = 1'b1;
      end
      @(negedge clk);
      if (bus.err) err_seen++;
      if (bus.VPU_data_we) begin
        strobe_at = n;
        check_int({tag, " sb nonempty"}, int'(sb_q.size() != 0), 1);
        if (sb_q.size() != 0) check_resp({tag, " data"}, observed(), sb_q.pop_front());
      end
      if (bus.VPU_rdy) first_rdy = n;
      @(posedge clk); #1;
      bus.start_VPU = 1'b0;
    end
    check_int({tag, " rdy cycle"}, first_rdy, exp_rdy);
    check_int({tag, " strobe cycle"}, strobe_at, exp_strobe);
    check_int({tag, " no err"}, err_seen, 0);
    @(negedge clk);
    check_int({tag, " strobe one cycle"}, int'(bus.VPU_data_we), 0);
    @(posedge clk); #1;
  endtask

  task automatic expect_reject(input string tag);
    for (int n = 1; n <= 3; n++) begin
      @(negedge clk);
      check_int($sformatf("%s c%0d err/rdy/we", tag, n),
                int'({bus.err, bus.VPU_rdy, bus.VPU_data_we}),
                (n == 1) ? 3'b110 : 3'b010);
      @(posedge clk); #1;
    end
  endtask

  task automatic run_draw(input string tag, input int ack_cyc,
                          input int exp_req, input int exp_rdy);
    int req_cnt   = 0;
    int first_rdy = 0;
    for (int n = 1; n <= 40 && first_rdy == 0; n++) begin
      if (n >= ack_cyc) bus.draw_ack = 1'b1;
      @(negedge clk);
      if (n == 1)
        check_int({tag, " attrs"},
                  int'({bus.draw_obj, bus.draw_type, bus.draw_color, bus.draw_fill}),
                  int'({5'd3, 2'd2, 3'd5, 1'b1}));
      if (bus.draw_req) req_cnt++;
      if (bus.VPU_rdy) first_rdy = n;
      @(posedge clk); #1;
    end
    bus.draw_ack = 1'b0;
    check_int({tag, " req cycles"}, req_cnt, exp_req);
    check_int({tag, " rdy cycle"}, first_rdy, exp_rdy);
    @(negedge clk);
    check_int({tag, " idle draw bus"},
              int'({bus.draw_req, bus.draw_obj, bus.draw_type, bus.draw_color, bus.draw_fill}), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mdl_vld[i] = 1'b0;
    rst = 1'b1;
    bus.start_VPU = 1'b0; bus.op_VPU = '0; bus.code_VPU = '0; bus.obj_num_VPU = '0;
    bus.obj_type_VPU = '0; bus.obj_color_VPU = '0; bus.fill_VPU = 1'b0;
    bus.RO_VPU = '0; bus.draw_ack = 1'b0;
    vtx = '0; a_type = 2'd0; a_color = 3'd0; a_fill = 1'b0;
    set_v(vtx);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // reset values
    @(negedge clk);
    check_int("reset rdy", int'(bus.VPU_rdy), 1);
    check_int("reset we/err/req", int'({bus.VPU_data_we, bus.err, bus.draw_req}), 0);
    check_resp("reset data", observed(), '0);
    check_int("reset draw bus", int'({bus.draw_obj, bus.draw_type, bus.draw_color, bus.draw_fill}), 0);
    @(posedge clk); #1;

    // NOP: nothing moves
    send(4'd0, 4'd0, 5'd3, 16'h0);
    for (int n = 1; n <= 3; n++) begin
      @(negedge clk);
      check_int($sformatf("nop c%0d status", n),
                int'({bus.err, bus.VPU_rdy, bus.VPU_data_we, bus.draw_req}), 4'b0100);
      check_resp($sformatf("nop c%0d data", n), observed(), '0);
      @(posedge clk); #1;
    end

    // LOAD obj 3 with a stray start mid-way, then READ back
    for (int i = 0; i < 8; i++) vtx[i] = 16'(i + 1);
    a_type = 2'd2; a_color = 3'd5; a_fill = 1'b1;
    send(4'd1, 4'd0, 5'd3, 16'h1234);
    wait_done("load3", 10, 0, 4);
    send(4'd2, 4'd0, 5'd3, 16'h0);
    wait_done("read3", 11, 11, 0);

    // XFORM add with wrap, then READ shows stored RO untouched
    send(4'd3, 4'd0, 5'd3, 16'hFFFF);
    wait_done("xf add", 17, 17, 0);
    send(4'd2, 4'd0, 5'd3, 16'h0);
    wait_done("read after add", 11, 11, 0);

    // XFORM subtract across zero
    send(4'd3, 4'd1, 5'd3, 16'h0002);
    wait_done("xf sub", 17, 17, 0);
    send(4'd2, 4'd0, 5'd3, 16'h0);
    wait_done("read after sub", 11, 11, 0);

    // ack while idle is ignored
    bus.draw_ack = 1'b1;
    @(negedge clk);
    check_int("stray ack", int'({bus.draw_req, bus.VPU_rdy}), 2'b01);
    @(posedge clk); #1;
    bus.draw_ack = 1'b0;

    // DRAW with ack arriving in cycle 6, then with ack already high
    send(4'd4, 4'd0, 5'd3, 16'h0);
    run_draw("draw late ack", 6, 6, 7);
    bus.draw_ack = 1'b1;
    send(4'd4, 4'd0, 5'd3, 16'h0);
    run_draw("draw early ack", 1, 1, 2);

    // rejections
    send(4'd2, 4'd0, 5'd7, 16'h0);
    expect_reject("read unloaded");
    send(4'd9, 4'd0, 5'd3, 16'h0);
    expect_reject("illegal op");

    // reset in the middle of a LOAD to obj 1
    for (int i = 0; i < 8; i++) vtx[i] = 16'(16'h0100 + i);
    send(4'd1, 4'd0, 5'd1, 16'h5555);
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b1;
    #1;
    check_int("midrst status", int'({bus.VPU_rdy, bus.VPU_data_we, bus.err, bus.draw_req}), 4'b1000);
    check_resp("midrst data", observed(), '0);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 32; i++) mdl_vld[i] = 1'b0;
    send(4'd2, 4'd0, 5'd1, 16'h0);
    expect_reject("read obj1 after rst");
    send(4'd2, 4'd0, 5'd3, 16'h0);
    expect_reject("read obj3 after rst");

    check_int("scoreboard drained", sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
